// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Configuration-chain controller for one routing tile chain (e.g. CBY connection
// box). Host words arrive over a valid/ready port and are shifted LSB first into
// ccff_head. config_enable is gated so exactly CHAIN_LEN bits move per load. The
// bits that fall out of ccff_tail are the old chain contents, and they come back
// to the host as readback words.

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // slot counts 0..WORD_W inclusive, so the increment on the word's last bit never wraps
    localparam int SLOT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [SLOT_W-1:0] r_slot;
    logic [WORD_W-1:0] r_sreg;
    logic [WORD_W-1:0] r_rdSreg;
    logic [WORD_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_err;

    logic              w_lastBit;
    logic              w_wordEnd;
    logic [WORD_W-1:0] w_rdNext;

    assign w_lastBit = (r_bitCnt == CNT_W'(CHAIN_LEN - 1));
    assign w_wordEnd = (r_slot == SLOT_W'(WORD_W - 1));

    // Readback word with the tail bit of this cycle merged into its slot position
    always_comb begin
        w_rdNext = r_rdSreg;
        for (int i = 0; i < WORD_W; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_rdNext[i] = ccff_tail;
            end
        end
    end

    // Load/shift sequencer: one host word per LOAD visit, one chain bit per SHIFT cycle
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= '0;
            r_slot    <= '0;
            r_sreg    <= '0;
            r_rdSreg  <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rdValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_bitCnt <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else if (wr_valid) begin
                        r_sreg   <= wr_data;
                        r_slot   <= '0;
                        r_rdSreg <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_sreg   <= r_sreg >> 1;
                        r_bitCnt <= r_bitCnt + 1'b1;
                        r_slot   <= r_slot + 1'b1;
                        r_rdSreg <= w_rdNext;
                        if (w_lastBit) begin
                            r_state   <= S_DONE;
                            r_rdData  <= w_rdNext;
                            r_rdValid <= 1'b1;
                        end else if (w_wordEnd) begin
                            r_state   <= S_LOAD;
                            r_rdData  <= w_rdNext;
                            r_rdValid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready      = (r_state == S_LOAD);
    assign config_enable = (r_state == S_SHIFT);
    assign ccff_head     = (r_state == S_SHIFT) & r_sreg[0];
    assign busy          = (r_state == S_LOAD) | (r_state == S_SHIFT);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign rd_valid      = r_rdValid;
    assign rd_data       = r_rdData;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
// Drives whole chain loads from a table of host words and expected readback words.
// A behavioural 36-bit tile chain model sits on ccff_head/ccff_tail. Hand-written
// sequences cover abort and mid-load reset.

module tb_ccff_chain_loader;

    localparam int CHAIN_LEN     = 36;
    localparam int WORD_W        = 8;
    localparam int CNT_W         = 6;
    localparam int NWORDS        = 5;
    localparam int BASE_DONE_CYC = 42;
    localparam int NVECS         = 6;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              start;
    logic              abort;
    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              config_enable;
    logic              ccff_head;
    logic              ccff_tail;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;

    logic [CHAIN_LEN-1:0] chainModel = '0;
    logic [WORD_W-1:0]    scoreboard[$];
    int                   checks = 0;
    int                   errors = 0;

    typedef struct {
        logic [WORD_W-1:0] words[NWORDS];
        logic [WORD_W-1:0] expRd[NWORDS];
        int                gapAt;
        int                gapLen;
        bit                checkRd;
        bit                startNoise;
    } loadVec_t;

    loadVec_t vecs[NVECS];

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .config_enable(config_enable),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Tile chain model: head enters at the top, the oldest bit leaves at index 0
    always @(posedge prog_clk) begin
        if (config_enable) begin
            chainModel <= {ccff_head, chainModel[CHAIN_LEN-1:1]};
        end
    end

    assign ccff_tail = chainModel[0];

    // Run-time guard so the bench always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One complete load driven from vecs[idx], checked cycle by cycle
    task automatic applyStimulus(input int idx);
        logic [NWORDS*WORD_W-1:0] allBits;
        logic [WORD_W-1:0]        expWord;
        int cyc      = 0;
        int wordIdx  = 0;
        int gapCnt   = 0;
        int shiftCnt = 0;
        int doneCnt  = 0;
        int doneCyc  = -1;
        int rdCnt    = 0;
        bit finished = 1'b0;
        for (int w = 0; w < NWORDS; w++) begin
            allBits[w*WORD_W +: WORD_W] = vecs[idx].words[w];
        end
        scoreboard.delete();
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(posedge prog_clk);
        while (!finished && cyc < 100) begin
            cyc++;
            #1;
            start = vecs[idx].startNoise && (cyc == 1 || cyc == 4 || cyc == 12 || cyc == 25);
            wr_valid = (wordIdx < NWORDS) && !(wordIdx == vecs[idx].gapAt && gapCnt < vecs[idx].gapLen);
            if (wr_valid) begin
                wr_data = vecs[idx].words[wordIdx];
            end else begin
                wr_data = WORD_W'($urandom);
            end
            @(negedge prog_clk);
            if (cyc == 1) begin
                checkOutput($sformatf("v%0d loadAfterStart", idx), wr_ready, 1);
                checkOutput($sformatf("v%0d errClearedByStart", idx), err, 0);
            end
            if (cyc == 2) begin
                checkOutput($sformatf("v%0d firstShiftCycle", idx), config_enable, 1);
            end
            if (wr_ready && wordIdx == vecs[idx].gapAt && gapCnt < vecs[idx].gapLen) begin
                checkOutput($sformatf("v%0d gapNoShift", idx), config_enable, 0);
                checkOutput($sformatf("v%0d gapHeadLow", idx), ccff_head, 0);
                gapCnt++;
            end
            if (config_enable) begin
                if (shiftCnt < CHAIN_LEN) begin
                    checkOutput($sformatf("v%0d headBit%0d", idx, shiftCnt), ccff_head, allBits[shiftCnt]);
                end
                shiftCnt++;
            end
            if (rd_valid) begin
                rdCnt++;
                if (vecs[idx].checkRd) begin
                    checkOutput($sformatf("v%0d readbackQueued", idx), scoreboard.size() > 0, 1);
                    if (scoreboard.size() > 0) begin
                        expWord = scoreboard.pop_front();
                        checkOutput($sformatf("v%0d readbackWord%0d", idx, rdCnt - 1), rd_data, expWord);
                    end
                end
            end
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
                if (vecs[idx].startNoise) start = 1'b1;
            end
            if (doneCyc >= 0 && cyc == doneCyc + 1) begin
                checkOutput($sformatf("v%0d idleAfterDone", idx), busy, 0);
                checkOutput($sformatf("v%0d noLoadAfterDone", idx), wr_ready, 0);
                finished = 1'b1;
            end
            if (wr_valid && wr_ready) begin
                if (vecs[idx].checkRd) scoreboard.push_back(vecs[idx].expRd[wordIdx]);
                wordIdx++;
            end
            @(posedge prog_clk);
        end
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        checkOutput($sformatf("v%0d doneSeen", idx), doneCyc >= 0, 1);
        checkOutput($sformatf("v%0d doneCycle", idx), doneCyc, BASE_DONE_CYC + vecs[idx].gapLen);
        checkOutput($sformatf("v%0d shiftCount", idx), shiftCnt, CHAIN_LEN);
        checkOutput($sformatf("v%0d doneCount", idx), doneCnt, 1);
        checkOutput($sformatf("v%0d readbackCount", idx), rdCnt, NWORDS);
        if (vecs[idx].checkRd) begin
            checkOutput($sformatf("v%0d scoreboardDrained", idx), scoreboard.size(), 0);
        end
        checkOutput($sformatf("v%0d errAfterLoad", idx), err, 0);
    endtask

    initial begin
        int shifts;
        int cyc;
        int wordIdx;
        int ceCnt;
        int doneCnt;
        int rdCnt;
        int loadCnt;

        vecs[0].words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h8F};
        vecs[0].expRd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].gapAt = -1; vecs[0].gapLen = 0; vecs[0].checkRd = 1'b1; vecs[0].startNoise = 1'b0;
        vecs[1].words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
        vecs[1].expRd = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0F};
        vecs[1].gapAt = -1; vecs[1].gapLen = 0; vecs[1].checkRd = 1'b1; vecs[1].startNoise = 1'b0;
        vecs[2].words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h8F};
        vecs[2].expRd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
        vecs[2].gapAt = -1; vecs[2].gapLen = 0; vecs[2].checkRd = 1'b1; vecs[2].startNoise = 1'b0;
        vecs[3].words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
        vecs[3].expRd = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0F};
        vecs[3].gapAt = 2; vecs[3].gapLen = 3; vecs[3].checkRd = 1'b1; vecs[3].startNoise = 1'b0;
        vecs[4].words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
        vecs[4].expRd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].gapAt = -1; vecs[4].gapLen = 0; vecs[4].checkRd = 1'b0; vecs[4].startNoise = 1'b1;
        vecs[5].words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h8F};
        vecs[5].expRd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05};
        vecs[5].gapAt = -1; vecs[5].gapLen = 0; vecs[5].checkRd = 1'b1; vecs[5].startNoise = 1'b0;

        pReset   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        repeat (2) @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        @(negedge prog_clk);
        checkOutput("resetWrReady", wr_ready, 0);
        checkOutput("resetConfigEnable", config_enable, 0);
        checkOutput("resetHead", ccff_head, 0);
        checkOutput("resetRdValid", rd_valid, 0);
        checkOutput("resetRdData", rd_data, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetErr", err, 0);

        for (int v = 0; v < NVECS; v++) begin
            if (v == 4) begin
                // Abort once 13 bits have gone out, during the following SHIFT cycle
                @(posedge prog_clk);
                #1;
                start = 1'b1;
                @(posedge prog_clk);
                #1;
                start   = 1'b0;
                shifts  = 0;
                wordIdx = 0;
                cyc     = 0;
                while (shifts < 13 && cyc < 60) begin
                    cyc++;
                    wr_valid = 1'b1;
                    wr_data  = (wordIdx == 0) ? 8'hC3 : 8'h5A;
                    @(negedge prog_clk);
                    if (config_enable) shifts++;
                    if (wr_valid && wr_ready) wordIdx++;
                    @(posedge prog_clk);
                    #1;
                end
                checkOutput("abortReachedBit13", shifts, 13);
                abort = 1'b1;
                @(negedge prog_clk);
                checkOutput("abortDuringShift", config_enable, 1);
                @(posedge prog_clk);
                #1;
                abort    = 1'b0;
                wr_valid = 1'b0;
                @(negedge prog_clk);
                checkOutput("abortIdleBusy", busy, 0);
                checkOutput("abortNoShift", config_enable, 0);
                checkOutput("abortErrSet", err, 1);
                checkOutput("abortNoDone", done, 0);
                checkOutput("abortNoLoad", wr_ready, 0);
                ceCnt   = 0;
                doneCnt = 0;
                rdCnt   = 0;
                loadCnt = 0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge prog_clk);
                    if (config_enable) ceCnt++;
                    if (done) doneCnt++;
                    if (rd_valid) rdCnt++;
                    if (wr_ready) loadCnt++;
                end
                checkOutput("postAbortShifts", ceCnt, 0);
                checkOutput("postAbortDone", doneCnt, 0);
                checkOutput("postAbortReadback", rdCnt, 0);
                checkOutput("postAbortLoad", loadCnt, 0);
                checkOutput("errSticky", err, 1);
            end
            applyStimulus(v);
        end

        // Reset in the middle of the first word's shifting
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h96;
        shifts   = 0;
        cyc      = 0;
        while (shifts < 5 && cyc < 40) begin
            cyc++;
            @(negedge prog_clk);
            if (config_enable) shifts++;
            if (shifts < 5) begin
                @(posedge prog_clk);
                #1;
            end
        end
        checkOutput("resetReachedBit5", shifts, 5);
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        pReset   = 1'b0;
        wr_valid = 1'b0;
        @(negedge prog_clk);
        checkOutput("midResetWrReady", wr_ready, 0);
        checkOutput("midResetConfigEnable", config_enable, 0);
        checkOutput("midResetHead", ccff_head, 0);
        checkOutput("midResetRdValid", rd_valid, 0);
        checkOutput("midResetRdData", rd_data, 0);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetDone", done, 0);
        checkOutput("midResetErr", err, 0);
        doneCnt = 0;
        loadCnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge prog_clk);
            if (done) doneCnt++;
            if (busy) loadCnt++;
        end
        checkOutput("midResetNoDone", doneCnt, 0);
        checkOutput("midResetStaysIdle", loadCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
